// File: rtl/crono_pkg.sv
// Shared definitions for the chronometer register responder: register map,
// BCD field limits, strobe FSM encoding and the write-data BCD check.
package crono_pkg;

  localparam int unsigned ADDR_W = 8;

  localparam logic [7:0] ADDR_SEG  = 8'h01;
  localparam logic [7:0] ADDR_MIN  = 8'h02;
  localparam logic [7:0] ADDR_HR   = 8'h03;
  localparam logic [7:0] ADDR_CTRL = 8'h04;

  localparam logic [7:0] LIM_MS = 8'h59;
  localparam logic [7:0] LIM_HR = 8'h23;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_RD_HOLD = 3'd2,
    ST_WR_WAIT = 3'd3,
    ST_WR_HOLD = 3'd4
  } state_e;

  // True when both nibbles are decimal digits and the value fits the field.
  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] lim);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= lim);
  endfunction

endpackage

// File: rtl/bcd_inc.sv
// Combinational two-digit BCD increment with wrap at a field limit.
module bcd_inc (
  input  logic [7:0] value_i,
  input  logic [7:0] limit_i,
  output logic [7:0] next_o,
  output logic       wrap_o
);

  // Next BCD value; reaching (or exceeding) the limit wraps to zero and flags a carry
  always_comb begin
    next_o = value_i;
    wrap_o = 1'b0;
    if (value_i >= limit_i) begin
      next_o = 8'h00;
      wrap_o = 1'b1;
    end else if (value_i[3:0] >= 4'd9) begin
      next_o = {value_i[7:4] + 4'd1, 4'h0};
    end else begin
      next_o = {value_i[7:4], value_i[3:0] + 4'd1};
    end
  end

endmodule

// File: rtl/crono_reg_responder.sv
// Chronometer register target: qualifies RD/WR strobes by pulse width,
// services the seg/min/hr/ctrl registers and runs the BCD count on tick_1hz.
module crono_reg_responder
  import crono_pkg::*;
#(
  parameter int unsigned MIN_PULSE = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] dir_in,
  input  logic              rd_in,
  input  logic              wr_in,
  input  logic [7:0]        data_in,
  input  logic              tick_1hz,
  output logic [7:0]        data_out,
  output logic              ack,
  output logic              err,
  output logic [7:0]        seg,
  output logic [7:0]        min,
  output logic [7:0]        hr
);

  localparam int unsigned    CNT_W    = 9;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MIN_PULSE - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             ack_q, ack_d, err_q, err_d;
  logic [7:0]       seg_q, seg_d, min_q, min_d, hr_q, hr_d;
  logic             run_q, run_d;
  // Previous strobe levels; reset high so a strobe held through reset release is not a rise
  logic             rd_prev_q, wr_prev_q;

  logic             rd_rise_s, wr_rise_s, wr_commit_s, tick_s;
  logic             addr_ok_s, data_ok_s;
  logic [7:0]       rd_data_s;
  logic [7:0]       seg_inc_s, min_inc_s, hr_inc_s;
  logic             seg_wrap_s, min_wrap_s, hr_wrap_s;

  assign rd_rise_s = rd_in & ~rd_prev_q;
  assign wr_rise_s = wr_in & ~wr_prev_q;
  assign tick_s    = run_q & tick_1hz;

  bcd_inc u_seg_inc (.value_i(seg_q), .limit_i(LIM_MS), .next_o(seg_inc_s), .wrap_o(seg_wrap_s));
  bcd_inc u_min_inc (.value_i(min_q), .limit_i(LIM_MS), .next_o(min_inc_s), .wrap_o(min_wrap_s));
  bcd_inc u_hr_inc  (.value_i(hr_q),  .limit_i(LIM_HR), .next_o(hr_inc_s),  .wrap_o(hr_wrap_s));

  // Address decode: read mux, address validity and write-data range check
  always_comb begin
    rd_data_s = 8'h00;
    addr_ok_s = 1'b1;
    data_ok_s = 1'b1;
    case (dir_in)
      ADDR_SEG:  begin rd_data_s = seg_q;          data_ok_s = bcd_ok(data_in, LIM_MS); end
      ADDR_MIN:  begin rd_data_s = min_q;          data_ok_s = bcd_ok(data_in, LIM_MS); end
      ADDR_HR:   begin rd_data_s = hr_q;           data_ok_s = bcd_ok(data_in, LIM_HR); end
      ADDR_CTRL: begin rd_data_s = {7'b0, run_q};  data_ok_s = 1'b1; end
      default:   begin rd_data_s = 8'h00;          addr_ok_s = 1'b0; end
    endcase
  end

  // Strobe FSM: pulse-width qualification, commit, ack/err generation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_out_d  = data_out_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    wr_commit_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((rd_rise_s || wr_rise_s) && rd_in && wr_in) begin
          err_d = 1'b1;
        end else if (rd_rise_s) begin
          state_d = ST_RD_WAIT;
          cnt_d   = 9'd1;
        end else if (wr_rise_s) begin
          state_d = ST_WR_WAIT;
          cnt_d   = 9'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        if (!rd_in || wr_rise_s) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = 9'd0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = cnt_q + 9'd1;
          state_d = ST_RD_HOLD;
          if (addr_ok_s) begin
            data_out_d = rd_data_s;
            ack_d      = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      ST_WR_WAIT: begin
        if (!wr_in || rd_rise_s) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = 9'd0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = cnt_q + 9'd1;
          state_d = ST_WR_HOLD;
          if (addr_ok_s && data_ok_s) begin
            wr_commit_s = 1'b1;
            ack_d       = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      ST_RD_HOLD: begin
        err_d = wr_rise_s;
        if (!rd_in) begin
          state_d = ST_IDLE;
          cnt_d   = 9'd0;
        end else begin
          state_d = ST_RD_HOLD;
        end
      end
      ST_WR_HOLD: begin
        err_d = rd_rise_s;
        if (!wr_in) begin
          state_d = ST_IDLE;
          cnt_d   = 9'd0;
        end else begin
          state_d = ST_WR_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 9'd0;
      end
    endcase
  end

  // Register file: BCD count cascade, then a committed write overrides its own field
  always_comb begin
    seg_d = tick_s ? seg_inc_s : seg_q;
    min_d = (tick_s && seg_wrap_s) ? min_inc_s : min_q;
    hr_d  = (tick_s && seg_wrap_s && min_wrap_s) ? hr_inc_s : hr_q;
    run_d = run_q;
    if (wr_commit_s) begin
      case (dir_in)
        ADDR_SEG:  seg_d = data_in;
        ADDR_MIN:  min_d = data_in;
        ADDR_HR:   hr_d  = data_in;
        ADDR_CTRL: run_d = data_in[0];
        default:   run_d = run_q;
      endcase
    end else begin
      run_d = run_q;
    end
  end

  // State and output registers; async reset returns everything to idle/zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 9'd0;
      data_out_q <= 8'h00;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      seg_q      <= 8'h00;
      min_q      <= 8'h00;
      hr_q       <= 8'h00;
      run_q      <= 1'b0;
      rd_prev_q  <= 1'b1;
      wr_prev_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      seg_q      <= seg_d;
      min_q      <= min_d;
      hr_q       <= hr_d;
      run_q      <= run_d;
      rd_prev_q  <= rd_in;
      wr_prev_q  <= wr_in;
    end
  end

  assign data_out = data_out_q;
  assign ack      = ack_q;
  assign err      = err_q;
  assign seg      = seg_q;
  assign min      = min_q;
  assign hr       = hr_q;

endmodule

// File: tb/tb_crono_reg_responder.sv
// Directed testbench for crono_reg_responder.
module tb_crono_reg_responder;
  import crono_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] dir_in, data_in;
  logic       rd_in, wr_in, tick_1hz;
  logic [7:0] data_out, seg, min, hr;
  logic       ack, err;

  int total = 0;
  int bad = 0;

  crono_reg_responder dut (
    .clk(clk), .reset(reset), .dir_in(dir_in), .rd_in(rd_in), .wr_in(wr_in),
    .data_in(data_in), .tick_1hz(tick_1hz), .data_out(data_out), .ack(ack),
    .err(err), .seg(seg), .min(min), .hr(hr)
  );

  always #5 clk = ~clk;

  // Drive one strobe for n cycles (optionally a tick on cycle tick_at), then 3 idle cycles.
  // Reports ack/err pulse counts, cycle of first ack and data_out seen with it.
  task automatic do_strobe(input bit is_wr, input logic [7:0] dir, input logic [7:0] data,
                           input int n, input int tick_at,
                           output int acks, output int errs, output int ack_cyc,
                           output logic [7:0] dout);
    acks = 0; errs = 0; ack_cyc = -1; dout = 8'hxx;
    dir_in = dir; data_in = data;
    if (is_wr) wr_in = 1'b1; else rd_in = 1'b1;
    for (int k = 1; k <= n + 3; k++) begin
      if (k == n + 1) begin wr_in = 1'b0; rd_in = 1'b0; end
      tick_1hz = (k == tick_at);
      @(posedge clk);
      @(negedge clk);
      tick_1hz = 1'b0;
      if (ack) begin
        acks++;
        if (ack_cyc < 0) begin ack_cyc = k; dout = data_out; end
      end
      if (err) errs++;
    end
  endtask

  task automatic do_tick();
    tick_1hz = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tick_1hz = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; rd_in = 1'b0; wr_in = 1'b0; tick_1hz = 1'b0;
    dir_in = 8'h00; data_in = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({seg, min, hr, data_out, ack, err} !== {8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_values: got seg=%h min=%h hr=%h dout=%h ack=%b err=%b want all zero",
               seg, min, hr, data_out, ack, err);
    end
  endtask

  task automatic test_write();
    int a, e, c; logic [7:0] d;
    do_strobe(1'b1, 8'h02, 8'h45, 256, 0, a, e, c, d);
    total++; if (c !== 256) begin bad++; $display("FAIL write_ack_cycle: got %0d want 256", c); end
    total++; if (a !== 1) begin bad++; $display("FAIL write_ack_count: got %0d want 1", a); end
    total++; if (e !== 0) begin bad++; $display("FAIL write_err: got %0d want 0", e); end
    total++; if (min !== 8'h45) begin bad++; $display("FAIL write_min: got %h want 45", min); end
  endtask

  task automatic test_read();
    int a, e, c; logic [7:0] d;
    do_strobe(1'b0, 8'h02, 8'h00, 300, 0, a, e, c, d);
    total++; if (c !== 256) begin bad++; $display("FAIL read_ack_cycle: got %0d want 256", c); end
    total++; if (d !== 8'h45) begin bad++; $display("FAIL read_data: got %h want 45", d); end
    total++; if (a !== 1 || e !== 0) begin bad++; $display("FAIL read_single_ack: got ack=%0d err=%0d want 1/0", a, e); end
    total++; if (dut.state_q !== ST_IDLE) begin bad++; $display("FAIL read_idle: got %0d want %0d", dut.state_q, ST_IDLE); end
    total++; if (data_out !== 8'h45) begin bad++; $display("FAIL read_hold: got %h want 45", data_out); end
  endtask

  task automatic test_short_pulse();
    int a, e, c; logic [7:0] d;
    do_strobe(1'b1, 8'h01, 8'h30, 100, 0, a, e, c, d);
    total++; if (e !== 1 || a !== 0) begin bad++; $display("FAIL short_pulse: got err=%0d ack=%0d want 1/0", e, a); end
    total++; if (seg !== 8'h00) begin bad++; $display("FAIL short_seg: got %h want 00", seg); end
    do_strobe(1'b1, 8'h01, 8'h30, 255, 0, a, e, c, d);
    total++; if (e !== 1 || a !== 0) begin bad++; $display("FAIL pulse_255: got err=%0d ack=%0d want 1/0", e, a); end
  endtask

  task automatic test_cascade();
    int a, e, c; logic [7:0] d;
    do_strobe(1'b1, 8'h03, 8'h23, 256, 0, a, e, c, d);
    do_strobe(1'b1, 8'h02, 8'h59, 256, 0, a, e, c, d);
    do_strobe(1'b1, 8'h01, 8'h59, 256, 0, a, e, c, d);
    total++; if ({hr, min, seg} !== 24'h235959) begin bad++; $display("FAIL cascade_setup: got %h%h%h want 235959", hr, min, seg); end
    do_tick();
    total++; if ({hr, min, seg} !== 24'h235959) begin bad++; $display("FAIL tick_while_stopped: got %h%h%h want 235959", hr, min, seg); end
    do_strobe(1'b1, 8'h04, 8'h01, 256, 0, a, e, c, d);
    do_tick();
    total++; if ({hr, min, seg} !== 24'h000000) begin bad++; $display("FAIL cascade_wrap: got %h%h%h want 000000", hr, min, seg); end
    do_strobe(1'b1, 8'h01, 8'h09, 256, 0, a, e, c, d);
    do_tick();
    total++; if (seg !== 8'h10) begin bad++; $display("FAIL nibble_carry: got %h want 10", seg); end
    do_strobe(1'b0, 8'h04, 8'h00, 256, 0, a, e, c, d);
    total++; if (d !== 8'h01) begin bad++; $display("FAIL read_ctrl: got %h want 01", d); end
  endtask

  task automatic test_tick_write();
    int a, e, c; logic [7:0] d;
    do_strobe(1'b1, 8'h02, 8'h10, 256, 0, a, e, c, d);
    do_strobe(1'b1, 8'h01, 8'h59, 256, 0, a, e, c, d);
    do_strobe(1'b1, 8'h01, 8'h30, 256, 256, a, e, c, d);
    total++; if ({hr, min, seg} !== 24'h001130) begin bad++; $display("FAIL tick_write: got %h%h%h want 001130", hr, min, seg); end
  endtask

  task automatic test_rejects();
    int a, e, c; logic [7:0] d;
    do_strobe(1'b1, 8'h01, 8'h6A, 256, 0, a, e, c, d);
    total++; if (e !== 1 || a !== 0 || seg !== 8'h30) begin bad++; $display("FAIL bad_bcd: got err=%0d ack=%0d seg=%h want 1/0/30", e, a, seg); end
    do_strobe(1'b1, 8'h03, 8'h24, 256, 0, a, e, c, d);
    total++; if (e !== 1 || a !== 0 || hr !== 8'h00) begin bad++; $display("FAIL hr_limit: got err=%0d ack=%0d hr=%h want 1/0/00", e, a, hr); end
    do_strobe(1'b1, 8'h07, 8'h15, 256, 0, a, e, c, d);
    total++; if (e !== 1 || a !== 0 || {hr, min, seg} !== 24'h001130) begin bad++; $display("FAIL bad_addr_wr: got err=%0d ack=%0d regs=%h%h%h want 1/0/001130", e, a, hr, min, seg); end
    do_strobe(1'b0, 8'h00, 8'h00, 256, 0, a, e, c, d);
    total++; if (e !== 1 || a !== 0 || data_out !== 8'h01) begin bad++; $display("FAIL bad_addr_rd: got err=%0d ack=%0d dout=%h want 1/0/01", e, a, data_out); end
  endtask

  task automatic test_rd_wr_together();
    int a, e;
    a = 0; e = 0;
    dir_in = 8'h01; data_in = 8'h22; rd_in = 1'b1; wr_in = 1'b1;
    for (int k = 1; k <= 263; k++) begin
      if (k == 261) begin rd_in = 1'b0; wr_in = 1'b0; end
      @(posedge clk); @(negedge clk);
      if (ack) a++;
      if (err) e++;
    end
    total++; if (e !== 1 || a !== 0 || seg !== 8'h30) begin bad++; $display("FAIL rd_wr_together: got err=%0d ack=%0d seg=%h want 1/0/30", e, a, seg); end
    a = 0; e = 0;
    dir_in = 8'h02; rd_in = 1'b1;
    for (int k = 1; k <= 303; k++) begin
      if (k == 50) wr_in = 1'b1;
      if (k == 301) begin rd_in = 1'b0; wr_in = 1'b0; end
      @(posedge clk); @(negedge clk);
      if (ack) a++;
      if (err) e++;
    end
    total++; if (e !== 1 || a !== 0) begin bad++; $display("FAIL opposite_abort: got err=%0d ack=%0d want 1/0", e, a); end
  endtask

  task automatic test_reset_mid_access();
    int a, e, c; logic [7:0] d;
    a = 0; e = 0;
    dir_in = 8'h02; data_in = 8'h12; wr_in = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); @(negedge clk);
      if (ack) a++;
    end
    reset = 1'b1;
    #1;
    total++; if ({seg, min, hr, data_out, ack, err} !== {8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0}) begin
      bad++; $display("FAIL reset_mid_regs: got seg=%h min=%h hr=%h dout=%h ack=%b err=%b want all zero", seg, min, hr, data_out, ack, err);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 303; k++) begin
      if (k == 301) wr_in = 1'b0;
      @(posedge clk); @(negedge clk);
      if (ack) a++;
      if (err) e++;
    end
    total++; if (a !== 0 || e !== 0 || min !== 8'h00) begin bad++; $display("FAIL held_strobe_ignored: got ack=%0d err=%0d min=%h want 0/0/00", a, e, min); end
    do_strobe(1'b1, 8'h02, 8'h12, 256, 0, a, e, c, d);
    total++; if (c !== 256 || min !== 8'h12) begin bad++; $display("FAIL write_after_reset: got cyc=%0d min=%h want 256/12", c, min); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_short_pulse();
    test_cascade();
    test_tick_write();
    test_rejects();
    test_rd_wr_together();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
